bira_top: RTL and testbench
===========================

# bira_top

Built-in redundancy analysis (BIRA) block for a 16x16 memory with a built-in fault model. While `test` is high it scans all 256 addresses, records faulty cells in an 8-entry fault store, then exhaustively searches a row/column spare allocation over 4 spares. It reports the allocation on `solution`, or flags unrepairability on `early_term`. It is the top of the BIRA subsystem and is driven directly by a test controller.

## Interface
- `FAULT_NUM`, default 5: number of valid entries in `FAULT_LIST` (0..12).
- `FAULT_LIST`, 96 bits, default {(1,2),(1,5),(3,2),(7,7),(9,2)} in entries 0..4: entry i = {row[3:0], col[3:0]} at bits [8i+7:8i]. Entries are distinct.
- `clk`  in  1  clock; all state on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `test`  in  1  start/hold request for scan+analysis.
- `spare_struct`  in  2  spare split R/C: 00 = 1R/3C, 01 = 2R/2C, 10 = 3R/1C, 11 = 4R/0C.
- `repair`  out  1  high while analysis runs.
- `early_term`  out  1  sticky unrepairable/overflow flag.
- `solution`  out  16  spare addresses: {slot3, slot2, slot1, slot0}, 4 bits each.
- `test_end_for_time`  out  1  one-cycle pulse when the scan completes.

## Operation
- States: IDLE, SCAN, ANALYZE, DONE, FAIL.
- Reset (async): state IDLE, all outputs 0, fault store and counters cleared.
- IDLE: if `test`=1, go to SCAN with address 0.
- SCAN: address {row, col} increments by one per cycle (col is the LSBs), covering 0..255.
  - A cell is faulty if it matches any valid `FAULT_LIST` entry.
  - Faulty cells are appended to the store in scan order, giving indices f0..fN-1.
  - A 9th fault sets the overflow flag (see Configuration).
  - `test`=0 during SCAN returns to IDLE and clears the store.
- End of scan (address 255 processed): go to ANALYZE; `test_end_for_time`=1 for exactly that first ANALYZE cycle; `repair`=1.
- ANALYZE: evaluates combination c = 0, 1, … 2^N−1, one per cycle. Bit i of c = 1 assigns fault fi to a column spare, 0 to a row spare.
  - c is feasible if distinct rows among row-assigned faults ≤ R and distinct columns among column-assigned faults ≤ C.
  - First feasible c: next state DONE, `repair`=0, `solution` registered.
  - N=0: c=0 is feasible and gives solution 0.
- Solution encoding:
  - Slots 0..R−1 hold distinct rows in increasing fault-index order of first occurrence.
  - Slots R..3 hold distinct columns in the same order.
  - Unused slots are 0.
- No feasible c after 2^N−1: go to FAIL; `repair`=0; `early_term`=1; `solution`=0.
- DONE/FAIL hold until reset; `test` is ignored there.
- `spare_struct` is sampled at entry to ANALYZE.

## Timing
- `test` high in IDLE → SCAN on the next edge; scan lasts 256 cycles.
- `test_end_for_time` rises 256 cycles after SCAN entry.
- `repair` stays high for (c_found + 1) cycles; it falls together with `solution` becoming valid.
- `early_term` rises on the same edge as entry to FAIL and stays high until `rst`.
- A reset mid-operation aborts immediately to IDLE with all outputs 0.

## Configuration
- `BIRA_EARLY_TERM_EN` defined: on overflow, SCAN stops that cycle and goes to FAIL. `early_term`=1; `test_end_for_time` and `repair` never assert.
- `BIRA_EARLY_TERM_EN` undefined: overflow is only latched. The scan completes, `test_end_for_time` pulses, then the block goes directly to FAIL (`early_term`=1) without analysis; `repair` stays 0.

## Structure
- Package `bira_pkg` holds:
  - state enum;
  - `fault_t` {row, col} typedef;
  - constants ADDR_W=4, CAM_DEPTH=8, SPARES=4;
  - function decoding `spare_struct` to R/C.
- Sub-module `bira_spare_analyzer`: purely combinational. Inputs are the fault store, N, c, R and C; outputs are feasible and the packed slot vector. The top holds the FSM, scan counter and fault store.

## Test plan
- Defaults, `spare_struct`=01, `test`=1 → `test_end_for_time` after 256 cycles; `repair` high 8 cycles; `solution`=16'h5297; `early_term`=0.
- Defaults, `spare_struct`=00 → `repair` high 16 cycles; `solution`=16'h7529.
- `FAULT_LIST` = diagonal (0,0)..(4,4), N=5, `spare_struct`=01 → 32 analysis cycles, `repair` falls, `early_term`=1, `solution`=0.
- N=9 distinct faults, macro defined → `early_term`=1 in the cycle after the 9th fault is detected; `repair` never rises.
- Same stimulus, macro undefined → `test_end_for_time` pulse at cycle 256, then `early_term`=1 with no `repair`.
- `rst` asserted mid-ANALYZE, then released with `test`=1 → outputs 0 immediately; a full rerun gives the same `solution`.

Source files
------------

// File: rtl/bira_pkg.sv
// Shared types and constants for the BIRA block: FSM states, fault record,
// spare geometry and the spare_struct -> row/column spare split decoder.
package bira_pkg;

    localparam int ADDR_W    = 4;
    localparam int CAM_DEPTH = 8;
    localparam int SPARES    = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_ANALYZE,
        ST_DONE,
        ST_FAIL
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] row;
        logic [ADDR_W-1:0] col;
    } fault_t;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] c;
    } spare_cfg_t;

    function automatic spare_cfg_t decode_spares(input logic [1:0] s);
        spare_cfg_t cfg;
        cfg.r = {1'b0, s} + 3'd1;
        cfg.c = 3'd4 - cfg.r;
        return cfg;
    endfunction

endpackage

// File: rtl/bira_spare_analyzer.sv
// Combinational feasibility check of one row/column assignment c over the
// fault store, producing the packed spare-address slots.
module bira_spare_analyzer
    import bira_pkg::*;
(
    input  fault_t [CAM_DEPTH-1:0]        faults_i,
    input  logic   [3:0]                  n_i,
    input  logic   [CAM_DEPTH-1:0]        comb_i,
    input  logic   [2:0]                  r_i,
    input  logic   [2:0]                  c_i,
    output logic                          feasible_o,
    output logic   [SPARES*ADDR_W-1:0]    slots_o
);

    logic [3:0]                          nr;
    logic [3:0]                          nc;
    logic [3:0]                          cidx;
    logic                                dup;
    logic [SPARES-1:0][ADDR_W-1:0]       slot;

    always_comb begin
        nr   = '0;
        nc   = '0;
        cidx = '0;
        dup  = 1'b0;
        slot = '0;
        for (int unsigned i = 0; i < CAM_DEPTH; i++) begin
            if (4'(i) < n_i) begin
                // A line counts once: skip it if an earlier fault on the same spare type shares it
                dup = 1'b0;
                for (int unsigned j = 0; j < CAM_DEPTH; j++) begin
                    if (j < i && comb_i[j[2:0]] == comb_i[i[2:0]]) begin
                        if (comb_i[i[2:0]] ? (faults_i[j[2:0]].col == faults_i[i[2:0]].col)
                                           : (faults_i[j[2:0]].row == faults_i[i[2:0]].row))
                            dup = 1'b1;
                    end
                end
                if (!dup) begin
                    if (!comb_i[i[2:0]]) begin
                        if (nr < {1'b0, r_i})
                            slot[nr[1:0]] = faults_i[i[2:0]].row;
                        nr = nr + 4'd1;
                    end else begin
                        cidx = {1'b0, r_i} + nc;
                        if (nc < {1'b0, c_i})
                            slot[cidx[1:0]] = faults_i[i[2:0]].col;
                        nc = nc + 4'd1;
                    end
                end
            end
        end
        feasible_o = (nr <= {1'b0, r_i}) && (nc <= {1'b0, c_i});
        slots_o    = slot;
    end

endmodule

// File: rtl/bira_top.sv
// BIRA top: scans a 16x16 array against the built-in fault list, stores faults,
// then searches spare allocations. Optional feature macro: BIRA_EARLY_TERM_EN.
module bira_top
    import bira_pkg::*;
#(
    parameter int          FAULT_NUM  = 5,
    parameter logic [95:0] FAULT_LIST = 96'h0000_0000_0000_0092_7732_1512
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        test,
    input  logic [1:0]  spare_struct,
    output logic        repair,
    output logic        early_term,
    output logic [15:0] solution,
    output logic        test_end_for_time
);

    localparam logic [11:0][7:0] LIST = FAULT_LIST;

    state_t                    state_q, state_d;
    logic [2*ADDR_W-1:0]       addr_q, addr_d;
    logic [3:0]                cnt_q, cnt_d;
    fault_t [CAM_DEPTH-1:0]    store_q, store_d;
    logic                      ovf_q, ovf_d;
    logic [CAM_DEPTH-1:0]      comb_q, comb_d;
    spare_cfg_t                cfg_q, cfg_d;
    logic                      repair_q, repair_d;
    logic                      early_q, early_d;
    logic [15:0]               sol_q, sol_d;
    logic                      tend_q, tend_d;

    logic                      hit;
    logic                      overflow;
    logic                      feasible;
    logic [15:0]               slots;
    logic [8:0]                last_c;

    always_comb begin
        hit = 1'b0;
        for (int unsigned k = 0; k < 12; k++) begin
            if (int'(k) < FAULT_NUM && LIST[k[3:0]] == addr_q)
                hit = 1'b1;
        end
    end

    assign overflow = hit && (cnt_q == 4'(CAM_DEPTH));
    assign last_c   = (9'd1 << cnt_q) - 9'd1;

    bira_spare_analyzer u_analyzer (
        .faults_i   (store_q),
        .n_i        (cnt_q),
        .comb_i     (comb_q),
        .r_i        (cfg_q.r),
        .c_i        (cfg_q.c),
        .feasible_o (feasible),
        .slots_o    (slots)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            cnt_q    <= '0;
            store_q  <= '0;
            ovf_q    <= 1'b0;
            comb_q   <= '0;
            cfg_q    <= '0;
            repair_q <= 1'b0;
            early_q  <= 1'b0;
            sol_q    <= '0;
            tend_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            store_q  <= store_d;
            ovf_q    <= ovf_d;
            comb_q   <= comb_d;
            cfg_q    <= cfg_d;
            repair_q <= repair_d;
            early_q  <= early_d;
            sol_q    <= sol_d;
            tend_q   <= tend_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        store_d  = store_q;
        ovf_d    = ovf_q;
        comb_d   = comb_q;
        cfg_d    = cfg_q;
        repair_d = repair_q;
        early_d  = early_q;
        sol_d    = sol_q;
        tend_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (test) begin
                    state_d = ST_SCAN;
                    addr_d  = '0;
                    cnt_d   = '0;
                    store_d = '0;
                    ovf_d   = 1'b0;
                end
            end
            ST_SCAN: begin
                if (!test) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    store_d = '0;
                    ovf_d   = 1'b0;
                end else begin
                    addr_d = addr_q + 1'b1;
                    if (hit && !overflow) begin
                        store_d[cnt_q[2:0]] = fault_t'(addr_q);
                        cnt_d = cnt_q + 4'd1;
                    end
                    if (addr_q == '1) begin
                        tend_d = 1'b1;
                        cfg_d  = decode_spares(spare_struct);
                        comb_d = '0;
                        if (ovf_q || overflow) begin
                            state_d = ST_FAIL;
                            early_d = 1'b1;
                        end else begin
                            state_d  = ST_ANALYZE;
                            repair_d = 1'b1;
                        end
                    end
`ifdef BIRA_EARLY_TERM_EN
                    // Overflow wins over end-of-scan: abort before any pulse or analysis
                    if (overflow) begin
                        state_d  = ST_FAIL;
                        early_d  = 1'b1;
                        tend_d   = 1'b0;
                        repair_d = 1'b0;
                    end
`else
                    if (overflow)
                        ovf_d = 1'b1;
`endif
                end
            end
            ST_ANALYZE: begin
                if (feasible) begin
                    state_d  = ST_DONE;
                    repair_d = 1'b0;
                    sol_d    = slots;
                end else if (comb_q == last_c[CAM_DEPTH-1:0]) begin
                    state_d  = ST_FAIL;
                    repair_d = 1'b0;
                    early_d  = 1'b1;
                    sol_d    = '0;
                end else begin
                    comb_d = comb_q + 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    assign repair            = repair_q;
    assign early_term        = early_q;
    assign solution          = sol_q;
    assign test_end_for_time = tend_q;

endmodule

// File: tb/tb_bira_top.sv
// Scoreboard bench for bira_top: the driver queues hand-computed run outcomes,
// a monitor measures each run's output timeline and compares on completion.
module tb_bira_top;

    logic        clk = 1'b0;
    logic        rst;
    logic        test;
    logic [1:0]  spare;
    logic [3:0]  rep_v, et_v, tend_v;
    logic [15:0] sol_v [4];
    int          sel;

    always #5 clk = ~clk;

    bira_top u0 (
        .clk(clk), .rst(rst), .test(test), .spare_struct(spare),
        .repair(rep_v[0]), .early_term(et_v[0]), .solution(sol_v[0]), .test_end_for_time(tend_v[0])
    );
    bira_top #(.FAULT_NUM(5), .FAULT_LIST(96'h0000_0000_0000_0044_3322_1100)) u1 (
        .clk(clk), .rst(rst), .test(test), .spare_struct(spare),
        .repair(rep_v[1]), .early_term(et_v[1]), .solution(sol_v[1]), .test_end_for_time(tend_v[1])
    );
    bira_top #(.FAULT_NUM(9), .FAULT_LIST(96'h0000_0081_7161_5141_3121_1101)) u2 (
        .clk(clk), .rst(rst), .test(test), .spare_struct(spare),
        .repair(rep_v[2]), .early_term(et_v[2]), .solution(sol_v[2]), .test_end_for_time(tend_v[2])
    );
    bira_top #(.FAULT_NUM(0)) u3 (
        .clk(clk), .rst(rst), .test(test), .spare_struct(spare),
        .repair(rep_v[3]), .early_term(et_v[3]), .solution(sol_v[3]), .test_end_for_time(tend_v[3])
    );

    typedef struct {
        int          tend_k;
        int          rep_len;
        int          early_k;
        logic [15:0] sol;
        logic        early;
    } exp_t;

    exp_t q[$];
    int   errors   = 0;
    int   checks   = 0;
    int   done_cnt = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    // Monitor: k counts rising edges since the run's first SCAN edge
    int k, tend_k, tend_cnt, rep_len, early_k;
    bit active = 0, prev_go = 0, prev_rep = 0, prev_et = 0;

    initial begin
        forever begin
            bit   go;
            logic r, t, et;
            exp_t e;
            @(posedge clk);
            go = test && !rst;
            if (rst) begin
                active = 0;
            end else if (go && !prev_go) begin
                active = 1; k = 0; tend_k = -1; tend_cnt = 0;
                rep_len = 0; early_k = -1; prev_rep = 0; prev_et = 0;
            end else if (active) begin
                k++;
            end
            prev_go = go;
            #1;
            if (active && !rst) begin
                r  = rep_v[sel];
                t  = tend_v[sel];
                et = et_v[sel];
                if (t) begin
                    if (tend_k < 0) tend_k = k;
                    tend_cnt++;
                end
                if (r) rep_len++;
                if (et && early_k < 0) early_k = k;
                if ((prev_rep && !r) || (et && !prev_et)) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_completion: got completion at cycle %0d, expected none", k);
                    end else begin
                        e = q.pop_front();
                        chk("tend_cycle", tend_k, e.tend_k);
                        chk("tend_pulses", tend_cnt, (e.tend_k >= 0) ? 1 : 0);
                        chk("repair_cycles", rep_len, e.rep_len);
                        chk("early_cycle", early_k, e.early_k);
                        chk("solution", int'(sol_v[sel]), int'(e.sol));
                        chk("early_term", int'(et), int'(e.early));
                    end
                    active = 0;
                    done_cnt++;
                end
                prev_rep = r;
                prev_et  = et;
            end
        end
    end

    task automatic wait_done();
        int d0 = done_cnt;
        int n  = 0;
        while (done_cnt == d0 && n < 700) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt == d0) begin
            checks++;
            errors++;
            $display("FAIL timeout: no completion after %0d cycles, expected completion", n);
            q.delete();
        end
    endtask

    task automatic rst_checks(input int s, input string tag);
        chk({tag, "_repair"}, int'(rep_v[s]), 0);
        chk({tag, "_early"}, int'(et_v[s]), 0);
        chk({tag, "_tend"}, int'(tend_v[s]), 0);
        chk({tag, "_solution"}, int'(sol_v[s]), 0);
    endtask

    task automatic run(input int s, input logic [1:0] ss, input exp_t e);
        @(negedge clk);
        rst   = 1'b1;
        test  = 1'b1;
        sel   = s;
        spare = ss;
        #1;
        rst_checks(s, "reset");
        q.push_back(e);
        @(negedge clk);
        rst = 1'b0;
        wait_done();
    endtask

    initial begin
        exp_t e_def01, e_nine;
        rst   = 1'b1;
        test  = 1'b0;
        spare = 2'b00;
        sel   = 0;
        e_def01 = '{256, 8, -1, 16'h5297, 1'b0};
`ifdef BIRA_EARLY_TERM_EN
        e_nine  = '{-1, 0, 130, 16'h0000, 1'b1};
`else
        e_nine  = '{256, 0, 256, 16'h0000, 1'b1};
`endif
        repeat (2) @(negedge clk);

        run(0, 2'b01, e_def01);
        run(0, 2'b00, '{256, 16, -1, 16'h7529, 1'b0});
        run(0, 2'b10, '{256, 5, -1, 16'h2971, 1'b0});
        run(0, 2'b11, '{256, 1, -1, 16'h9731, 1'b0});
        run(1, 2'b01, '{256, 32, 288, 16'h0000, 1'b1});
        run(2, 2'b01, e_nine);
        run(3, 2'b01, '{256, 1, -1, 16'h0000, 1'b0});

        // Abort mid-analysis, then rerun with test held high through reset release
        @(negedge clk);
        rst   = 1'b1;
        test  = 1'b1;
        sel   = 0;
        spare = 2'b01;
        @(negedge clk);
        rst = 1'b0;
        repeat (260) @(posedge clk);
        #3;
        chk("mid_repair_before_rst", int'(rep_v[0]), 1);
        rst = 1'b1;
        #1;
        rst_checks(0, "mid_rst");
        q.push_back(e_def01);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        wait_done();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
